uart_rx_stream: RTL and testbench
=================================

// Module: uart_rx_stream
// PURPOSE
//   Fabric-side UART receiver (8N1) for bytes transmitted on the Nios UART txd pin.
//   Synchronises the serial line, deframes bytes with mid-bit sampling, and buffers
//   them in a first-word-fall-through FIFO with a valid/ready stream output.
//   Flags framing errors and FIFO overruns as single-cycle pulses.
// PARAMETERS
//   CLK_HZ       50_000_000  system clock frequency, Hz
//   BAUD         115200      line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer div), must be >= 4
//   FIFO_DEPTH   16          receive FIFO entries, power of two, >= 2
// PORTS
//   clk          in   1              system clock, all logic on rising edge
//   reset_n      in   1              asynchronous active-low reset
//   rxd          in   1              serial line, idle high, asynchronous to clk
//   m_data       out  8              head-of-FIFO byte, valid only while m_valid=1
//   m_valid      out  1              FIFO non-empty
//   m_ready      in   1              consumer accepts; pop when m_valid & m_ready
//   fifo_count   out  $clog2(FIFO_DEPTH)+1  entries held
//   frame_err    out  1              1-cycle pulse: stop bit sampled low
//   overrun      out  1              1-cycle pulse: byte completed while FIFO full
// BEHAVIOUR
//   Reset: m_data=0, m_valid=0, fifo_count=0, frame_err=0, overrun=0; FSM=IDLE;
//     synchroniser flops preset to 1 (line idle). Reset mid-frame discards the frame.
//   rxd passes a 2-flop synchroniser -> rx_s; all decisions use rx_s.
//   FSM states: IDLE, START, DATA, STOP, BREAK. Bit counter cnt, bit index idx (0..7).
//   IDLE: on rx_s=0 -> START, cnt=0.
//   START: at cnt=CLKS_PER_BIT/2-1 sample rx_s; 0 -> DATA, cnt=0, idx=0;
//     1 -> IDLE (glitch rejected, no flag).
//   DATA: at cnt=CLKS_PER_BIT-1 shift rx_s into shreg LSB first, cnt=0;
//     after idx=7 -> STOP.
//   STOP: at cnt=CLKS_PER_BIT-1 sample rx_s; 1 -> push shreg, -> IDLE;
//     0 -> frame_err pulse, byte discarded, -> BREAK.
//   BREAK: wait until rx_s=1, then -> IDLE (no new start detected during a break).
//   Push on full FIFO: byte dropped, overrun pulse, FIFO contents unchanged.
//   Simultaneous push and pop: both occur; count unchanged. If FIFO full and pop occurs
//     in the same cycle as push, the push is accepted (no overrun).
//   FWFT: byte pushed into empty FIFO gives m_valid=1 and m_data=byte on next cycle.
//   m_data/m_valid hold stable while m_valid=1 & m_ready=0.
//   Pop on empty ignored. Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
//   Latency: m_valid rises 1 clk after the stop-bit sample, i.e. 2 (sync) +
//     CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clks after the rxd falling edge.
// TESTING (CLK_HZ=1_000_000, BAUD=100_000 -> 10 clks/bit, FIFO_DEPTH=4)
//   1. Send 0xA5 8N1, m_ready=0 -> m_valid=1, m_data=8'hA5, fifo_count=1 at
//      clk 2+5+90+1=98 after start edge; no flags.
//   2. Send 0x00 with stop bit low, then line high -> frame_err one pulse,
//      fifo_count stays 0; next byte 0x3C received correctly.
//   3. 3-clk low glitch on idle rxd -> no byte, no flags, FSM back in IDLE.
//   4. m_ready=0, send 0x01..0x05 -> fifo_count=4, overrun pulses once on 5th byte;
//      then m_ready=1 drains 01,02,03,04 in order, m_valid=0 after.
//   5. FIFO full, raise m_ready the cycle the next stop bit is sampled -> no overrun,
//      count stays 4, last entry = new byte.
//   6. Assert reset_n=0 during DATA of byte 0x77 -> outputs at reset values, byte lost;
//      release and send 0x5A -> received 0x5A only.

Source files
------------

// File: rtl/uart_rx_stream.sv
// rtl/uart_rx_stream.sv - 8N1 UART receiver with FWFT byte FIFO and valid/ready output
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   rxd         serial line, idle high, asynchronous to clk
//   m_data      head-of-FIFO byte (0 while m_valid=0)
//   m_valid     FIFO non-empty
//   m_ready     consumer accepts head byte when m_valid=1
//   fifo_count  entries held, 0..FIFO_DEPTH
//   frame_err   1-cycle pulse, stop bit sampled low
//   overrun     1-cycle pulse, byte completed while FIFO full and not popping
module uart_rx_stream #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rxd,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Line synchroniser; presets to 1 so reset never looks like a start bit.
    logic [1:0] sync;
    logic       rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rxd};
        end
    end

    assign rx_s = sync[1];

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     idx, idx_n;
    logic [7:0]     shreg, shreg_n;
    logic           push_req;
    logic           ferr_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        shreg_n  = shreg;
        push_req = 1'b0;
        ferr_req = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                // Re-check the line mid start bit to reject short glitches.
                if (cnt == HALF_END) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    idx_n   = idx + 1'b1;
                    if (idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        push_req = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        ferr_req = 1'b1;
                        state_n  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must return high before a new start is accepted.
                cnt_n = '0;
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign full    = (count == FULL_CNT);
    assign m_valid = (count != '0);
    assign pop     = m_valid & m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok = push_req & (~full | pop);

    assign m_data     = m_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_req;
            overrun   <= push_req & ~push_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_stream.sv
// tb/tb_uart_rx_stream.sv - self-checking bench for uart_rx_stream
module tb_uart_rx_stream;

    localparam int CPB = 10;

    logic       clk;
    logic       reset_n;
    logic       rxd;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun;

    uart_rx_stream #(
        .CLK_HZ    (1_000_000),
        .BAUD      (100_000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rxd       (rxd),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .fifo_count(fifo_count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] got[$];
    bit         hold_prev = 0;
    logic [7:0] hold_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream monitor: records accepted bytes, counts flag cycles, checks hold-while-stalled.
    always @(negedge clk) begin
        if (reset_n) begin
            if (hold_prev) begin
                checks++;
                if (!m_valid || m_data !== hold_data) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=%0h expected valid=1 data=%0h",
                             m_valid, m_data, hold_data);
                end
            end
            if (m_valid && m_ready) got.push_back(m_data);
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
        end else begin
            hold_prev = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            idle(CPB);
        end
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int f0;
        int o0;
        logic [9:0] fr;
        logic [7:0] exp_q[$];
        int exp_ferr;
        bit done;

        vecs[0] = '{8'h00, 1'b0, 1'b0, 8'h00, 1};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vecs[3] = '{8'h80, 1'b0, 1'b0, 8'h00, 1};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};
        vecs[5] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};

        reset_n = 1'b0;
        rxd     = 1'b1;
        m_ready = 1'b0;
        idle(3);
        check("reset_valid", m_valid, 0);
        check("reset_data", m_data, 0);
        check("reset_count", fifo_count, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);
        reset_n = 1'b1;
        idle(3);

        // Exact latency for 0xA5: m_valid low after 97 edges, high after 98.
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        fr = {1'b1, 8'hA5, 1'b0};
        for (int n = 0; n < 100; n++) begin
            rxd = fr[n / 10];
            idle(1);
            if (n == 96) check("lat_before", m_valid, 0);
            if (n == 97) begin
                check("lat_valid", m_valid, 1);
                check("lat_data", m_data, 8'hA5);
                check("lat_count", fifo_count, 1);
            end
        end
        rxd = 1'b1;
        idle(3);
        check("lat_noferr", ferr_cnt - f0, 0);
        check("lat_noovr", ovr_cnt - o0, 0);
        m_ready = 1'b1;
        idle(2);
        m_ready = 1'b0;
        got.delete();

        // Table of single frames, consumer stalled, drained after each.
        for (int v = 0; v < 6; v++) begin
            f0 = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop_ok);
            idle(4);
            check($sformatf("vec%0d_valid", v), m_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d_count", v), fifo_count, vecs[v].exp_valid ? 1 : 0);
            check($sformatf("vec%0d_data", v), m_data, vecs[v].exp_data);
            check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            m_ready = 1'b1;
            idle(2);
            m_ready = 1'b0;
            check($sformatf("vec%0d_pops", v), got.size(), vecs[v].exp_valid ? 1 : 0);
            got.delete();
        end

        // Short low glitch on an idle line is ignored.
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        m_ready = 1'b1;
        rxd = 1'b0;
        idle(3);
        rxd = 1'b1;
        idle(30);
        check("glitch_count", fifo_count, 0);
        check("glitch_pops", got.size(), 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_ovr", ovr_cnt - o0, 0);
        send_frame(8'hC3, 1'b1);
        idle(3);
        check("glitch_next_n", got.size(), 1);
        if (got.size() > 0) check("glitch_next_d", got[0], 8'hC3);
        got.delete();

        // Overrun on the fifth byte, then in-order drain.
        m_ready = 1'b0;
        o0 = ovr_cnt;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        idle(3);
        check("ovr_count", fifo_count, 4);
        check("ovr_pulses", ovr_cnt - o0, 1);
        m_ready = 1'b1;
        idle(8);
        m_ready = 1'b0;
        check("ovr_drain_n", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            check($sformatf("ovr_drain%0d", i), got[i], i + 1);
        check("ovr_empty", m_valid, 0);
        got.delete();

        // Full FIFO with a pop on the exact push cycle: accepted, no overrun.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        idle(2);
        check("full_count", fifo_count, 4);
        o0 = ovr_cnt;
        fr = {1'b1, 8'h99, 1'b0};
        for (int n = 0; n < 100; n++) begin
            rxd = fr[n / 10];
            m_ready = (n == 97);
            idle(1);
        end
        m_ready = 1'b0;
        rxd = 1'b1;
        idle(3);
        check("simul_ovr", ovr_cnt - o0, 0);
        check("simul_count", fifo_count, 4);
        check("simul_pop_n", got.size(), 1);
        m_ready = 1'b1;
        idle(8);
        m_ready = 1'b0;
        check("simul_drain_n", got.size(), 5);
        if (got.size() == 5) begin
            check("simul_d1", got[1], 8'h22);
            check("simul_d4", got[4], 8'h99);
        end
        got.delete();

        // Reset mid-frame discards the partial byte and FIFO contents.
        send_frame(8'h42, 1'b1);
        idle(2);
        check("prerst_count", fifo_count, 1);
        fr = {1'b1, 8'h77, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rxd = fr[i];
            idle(CPB);
        end
        reset_n = 1'b0;
        rxd = 1'b1;
        idle(1);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_flags", {frame_err, overrun}, 0);
        idle(3);
        reset_n = 1'b1;
        idle(5);
        f0 = ferr_cnt;
        got.delete();
        m_ready = 1'b1;
        send_frame(8'h5A, 1'b1);
        idle(5);
        check("postrst_n", got.size(), 1);
        if (got.size() > 0) check("postrst_d", got[0], 8'h5A);
        check("postrst_ferr", ferr_cnt - f0, 0);
        got.delete();

        // Random frames and random back-pressure against a byte-queue model.
        exp_q.delete();
        exp_ferr = 0;
        f0 = ferr_cnt;
        done = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [7:0] b;
                    bit ok;
                    b  = 8'($urandom);
                    ok = ($urandom_range(0, 4) != 0);
                    if (ok) exp_q.push_back(b);
                    else exp_ferr++;
                    send_frame(b, ok);
                    idle(ok ? $urandom_range(0, 12) : $urandom_range(4, 12));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_ready = 1'b1;
        idle(10);
        check("rand_n", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) check($sformatf("rand_d%0d", i), got[i], exp_q[i]);
        check("rand_ferr", ferr_cnt - f0, exp_ferr);
        check("rand_empty", m_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
